// File: rtl/sound_pkg.sv
// Shared types and constants for the note sequencer
// and its FIFO.
package sound_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TONE,
    S_DUR,
    S_FIRE,
    S_PLAY,
    S_GAP,
    S_ABORT
  } seq_state_t;

  localparam logic SND_SEL_TONE = 1'b1;
  localparam logic SND_SEL_DUR  = 1'b0;

  typedef struct packed {
    logic [7:0] tone;
    logic [7:0] dur;
  } note_t;

endpackage

// File: rtl/sound_note_fifo.sv
// Show-ahead note queue with flush and an
// overflow pulse for dropped pushes.
module sound_note_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  note_t                    din,
  input  logic                     pop,
  input  logic                     flush,
  output note_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  note_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // a pop frees the slot the same-cycle push needs
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Plays queued (tone, duration) notes through the
// sound tone generator's data/enable interface.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DUR_SHIFT  = 21,
  parameter int GAP_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               push_tone,
  input  logic [7:0]               push_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     note_done,
  output logic                     snd_data_tx,
  output logic [8:0]               snd_data,
  output logic                     snd_enable
);

  localparam int WW = 8 + DUR_SHIFT;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_t    state;
  note_t         cur;
  note_t         head;
  logic          playing;
  logic          empty;
  logic          pop;
  logic          go;
  logic [WW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;

  // stop beats flush beats start
  assign go  = !stop && !flush && !empty
            && (start || playing);
  assign pop = go && ((state == S_IDLE)
            || (state == S_GAP && gap_cnt == '0));

  sound_note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .din      ({push_tone, push_dur}),
    .pop      (pop),
    .flush    (flush && !stop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      playing     <= 1'b0;
      cur         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      busy        <= 1'b0;
      note_done   <= 1'b0;
      snd_data_tx <= 1'b0;
      snd_data    <= '0;
      snd_enable  <= 1'b0;
    end else begin
      busy        <= (state != S_IDLE);
      snd_enable  <= (state == S_FIRE);
      snd_data_tx <= (state == S_TONE)
                  || (state == S_DUR)
                  || (state == S_ABORT);
      snd_data    <= '0;
      if (state == S_TONE)
        snd_data <= {SND_SEL_TONE, cur.tone};
      else if (state == S_DUR || state == S_ABORT)
        snd_data <= {SND_SEL_DUR, cur.dur};
      note_done   <= 1'b0;

      if (stop || flush) playing <= 1'b0;
      else if (start)    playing <= 1'b1;

      if (stop && state != S_IDLE
          && state != S_ABORT) begin
        state <= S_ABORT;
      end else begin
        unique case (state)
          S_IDLE: if (pop) begin
            cur   <= head;
            state <= S_TONE;
          end
          S_TONE: state <= S_DUR;
          S_DUR: begin
            wait_cnt <= '0;
            state    <= (cur.dur != '0) ? S_FIRE
                                        : S_PLAY;
          end
          S_FIRE: begin
            wait_cnt <= WW'(cur.dur) << DUR_SHIFT;
            state    <= S_PLAY;
          end
          S_PLAY: if (wait_cnt == '0) begin
            note_done <= 1'b1;
            gap_cnt   <= GW'(GAP_CYCLES - 1);
            state     <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
          S_GAP: if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (pop) begin
            cur   <= head;
            state <= S_TONE;
          end else begin
            playing <= 1'b0;
            state   <= S_IDLE;
          end
          S_ABORT: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: stimulus queues expected bus
// events, a negedge monitor pops and compares them.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_tone = '0;
  logic [7:0] push_dur = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       flush = 1'b0;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       note_done;
  logic       snd_data_tx;
  logic [8:0] snd_data;
  logic       snd_enable;

  sound_sequencer #(
    .DEPTH(16), .DUR_SHIFT(4), .GAP_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .push(push),
    .push_tone(push_tone), .push_dur(push_dur),
    .start(start), .stop(stop), .flush(flush),
    .full(full), .count(count), .overflow(overflow),
    .busy(busy), .note_done(note_done),
    .snd_data_tx(snd_data_tx), .snd_data(snd_data),
    .snd_enable(snd_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // event = {kind[2:0], data[8:0]}: 1 data, 2 enable, 3 done
  logic [11:0] exp_q[$];
  int          exp_cnt[$];
  int          dat_t[$];
  int          en_t[$];
  int          done_t[$];

  task automatic chk(input string name,
                     input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  task automatic check_ev(input logic [11:0] ev);
    logic [11:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event: got %h expected none",
               ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL event: got %h expected %h", ev, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (snd_data_tx) begin
        dat_t.push_back(cyc);
        check_ev({3'd1, snd_data});
        if (snd_data[8]) begin
          if (exp_cnt.size() == 0)
            chk("tone count", count, -1);
          else
            chk("tone count", count, exp_cnt.pop_front());
        end
      end
      if (snd_enable) begin
        en_t.push_back(cyc);
        check_ev({3'd2, 9'd0});
      end
      if (note_done) begin
        done_t.push_back(cyc);
        check_ev({3'd3, 9'd0});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_note(input int t, input int d);
    push = 1'b1;
    push_tone = 8'(t);
    push_dur = 8'(d);
    tick();
    push = 1'b0;
  endtask

  task automatic exp_note(input int t, input int d,
                          input int c, input bit done);
    exp_q.push_back({3'd1, 1'b1, 8'(t)});
    exp_q.push_back({3'd1, 1'b0, 8'(d)});
    if (d != 0) exp_q.push_back({3'd2, 9'd0});
    if (done) exp_q.push_back({3'd3, 9'd0});
    exp_cnt.push_back(c);
  endtask

  task automatic pulse(input int which, output int t);
    t = cyc;
    if (which == 0) start = 1'b1;
    if (which == 1) stop = 1'b1;
    if (which == 2) flush = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int n;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    if (!busy) chk("busy rise timeout", 0, 1);
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    if (busy) chk("busy fall timeout", 1, 0);
    t = cyc;
  endtask

  task automatic clear_t();
    dat_t.delete();
    en_t.delete();
    done_t.delete();
  endtask

  int ts, ti, n;

  initial begin
    tick();
    chk("rst count", count, 0);
    chk("rst busy", busy, 0);
    chk("rst outs", {full, overflow, note_done,
        snd_data_tx, snd_enable, snd_data}, 0);
    reset_n = 1'b1;
    tick();

    // single note
    clear_t();
    push_note(16, 3);
    chk("t1 count", count, 1);
    exp_note(16, 3, 0, 1);
    pulse(0, ts);
    wait_idle(ti);
    if (dat_t.size() >= 2 && en_t.size() >= 1
        && done_t.size() >= 1) begin
      chk("t1 start lat", dat_t[0] - ts, 2);
      chk("t1 fire->done", done_t[0] - en_t[0], 49);
      chk("t1 done->idle", ti - done_t[0], 9);
    end else chk("t1 events", dat_t.size(), 2);

    // three notes, one start
    clear_t();
    push_note(1, 1);
    push_note(2, 2);
    push_note(3, 1);
    chk("t2 count", count, 3);
    exp_note(1, 1, 2, 1);
    exp_note(2, 2, 1, 1);
    exp_note(3, 1, 0, 1);
    pulse(0, ts);
    wait_idle(ti);
    if (dat_t.size() >= 6 && done_t.size() >= 3) begin
      chk("t2 gap1", dat_t[2] - done_t[0], 9);
      chk("t2 gap2", dat_t[4] - done_t[1], 9);
      chk("t2 dur2", done_t[1] - en_t[1], 33);
    end else chk("t2 events", dat_t.size(), 6);
    push_note(4, 1);
    repeat (10) tick();
    chk("t2 playing cleared", busy, 0);
    pulse(2, ts);
    chk("t2 flush count", count, 0);

    // rest note
    clear_t();
    push_note(5, 0);
    exp_note(5, 0, 0, 1);
    pulse(0, ts);
    wait_idle(ti);
    if (dat_t.size() >= 2 && done_t.size() >= 1)
      chk("t3 rest done", done_t[0] - dat_t[1], 1);
    else chk("t3 events", dat_t.size(), 2);
    chk("t3 no enable", en_t.size(), 0);

    // stop mid-play
    clear_t();
    push_note(7, 5);
    push_note(8, 1);
    push_note(9, 2);
    exp_note(7, 5, 2, 0);
    exp_q.push_back({3'd1, 9'h005});
    pulse(0, ts);
    n = 0;
    while (en_t.size() == 0 && n < 50) begin
      tick(); n++;
    end
    if (en_t.size() == 0) chk("t4 enable timeout", 0, 1);
    repeat (10) tick();
    pulse(1, ts);
    wait_idle(ti);
    if (dat_t.size() >= 3)
      chk("t4 abort lat", dat_t[2] - ts, 2);
    else chk("t4 events", dat_t.size(), 3);
    chk("t4 queue kept", count, 2);
    pulse(2, ts);

    // full queue and overflow
    for (int i = 0; i < 16; i++) push_note(32 + i, 1);
    chk("t5 count full", count, 16);
    chk("t5 full", full, 1);
    push_note(99, 1);
    chk("t5 overflow", overflow, 1);
    chk("t5 count kept", count, 16);
    tick();
    chk("t5 overflow pulse", overflow, 0);
    exp_note(32, 1, 16, 0);
    clear_t();
    push = 1'b1;
    push_tone = 8'd48;
    push_dur = 8'd1;
    start = 1'b1;
    tick();
    push = 1'b0;
    start = 1'b0;
    chk("t5 push+pop count", count, 16);
    chk("t5 push+pop ovf", overflow, 0);

    // reset mid-play
    n = 0;
    while (en_t.size() == 0 && n < 50) begin
      tick(); n++;
    end
    if (en_t.size() == 0) chk("t6 enable timeout", 0, 1);
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6 rst count", count, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst outs", {full, overflow, note_done,
        snd_data_tx, snd_enable, snd_data}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6 scoreboard drained", exp_q.size(), 0);
    push_note(1, 1);
    repeat (10) tick();
    chk("t6 idle after reset", busy, 0);
    chk("t6 count", count, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
